// File: rtl/light_runner_pkg.sv
// Shared state codes and default timing constants for the light runner game.
package light_runner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_MISS = 2'd3
   } state_t;

   localparam int LR_STEP_TICKS_INIT = 20;
   localparam int LR_STEP_TICKS_MIN  = 6;
   localparam int LR_HOLD_TICKS      = 100;
   localparam int LR_SCORE_MAX       = 99;

endpackage

// File: rtl/light_runner_rise_detect.sv
// Optional synchronizer chain followed by a one-cycle rising-edge pulse.
module rise_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic din,
   output logic rise
);

   // sh_q[SYNC_STAGES-1] is the synchronized level, sh_q[SYNC_STAGES] its previous value
   logic [SYNC_STAGES:0] sh_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= {sh_q[SYNC_STAGES-1:0], din};
      end
   end

   assign rise = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];

endmodule

// File: rtl/light_runner.sv
// Reaction game: a lit LED runs along the bar; catch it at TARGET_IDX with the button.
// Define LIGHT_RUNNER_SPEEDUP_EN to shorten the step period by 2 ticks after every hit.
module light_runner
   import light_runner_pkg::*;
#(
   parameter int NUM_LEDS        = 8,
   parameter int TARGET_IDX      = 4,
   parameter int STEP_TICKS_INIT = LR_STEP_TICKS_INIT,
   parameter int STEP_TICKS_MIN  = LR_STEP_TICKS_MIN,
   parameter int HOLD_TICKS      = LR_HOLD_TICKS
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                slow_clk,
   input  logic                btn,
   output logic [NUM_LEDS-1:0] led,
   output logic [6:0]          score,
   output logic                hit,
   output logic                miss,
   output logic [1:0]          state
);

   localparam int POS_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int CNT_W  = $clog2(((STEP_TICKS_INIT > STEP_TICKS_MIN) ?
                                   STEP_TICKS_INIT : STEP_TICKS_MIN) + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   logic              tick, press;
   state_t            state_q, state_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [CNT_W-1:0]  tick_q, tick_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [6:0]        score_q, score_d;
   logic              hit_q, hit_d, miss_q, miss_d;

   function automatic logic [6:0] score_inc(input logic [6:0] s);
      return (s >= 7'(LR_SCORE_MAX)) ? s : s + 7'd1;
   endfunction

   function automatic logic [CNT_W-1:0] period_after_hit(input logic [CNT_W-1:0] p);
`ifdef LIGHT_RUNNER_SPEEDUP_EN
      return (p >= CNT_W'(STEP_TICKS_MIN + 2)) ? p - CNT_W'(2) : CNT_W'(STEP_TICKS_MIN);
`else
      return p;
`endif
   endfunction

   // slow_clk is already clean, so only one capture stage before edge detect
   rise_detect #(.SYNC_STAGES(1)) u_tick (
      .clk_in (clk_in),
      .rst    (rst),
      .din    (slow_clk),
      .rise   (tick)
   );

   rise_detect #(.SYNC_STAGES(2)) u_press (
      .clk_in (clk_in),
      .rst    (rst),
      .din    (btn),
      .rise   (press)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pos_q    <= '0;
         tick_q   <= '0;
         period_q <= CNT_W'(STEP_TICKS_INIT);
         hold_q   <= '0;
         score_q  <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         hold_q   <= hold_d;
         score_q  <= score_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      tick_d   = tick_q;
      period_d = period_q;
      hold_d   = hold_q;
      score_d  = score_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press) begin
               state_d  = ST_RUN;
               pos_d    = '0;
               tick_d   = '0;
               score_d  = '0;
               period_d = CNT_W'(STEP_TICKS_INIT);
            end
         end
         ST_RUN: begin
            // a press wins over a coincident step, judged on the current position
            if (press) begin
               hold_d = '0;
               if (pos_q == POS_W'(TARGET_IDX)) begin
                  state_d  = ST_HIT;
                  hit_d    = 1'b1;
                  score_d  = score_inc(score_q);
                  period_d = period_after_hit(period_q);
               end else begin
                  state_d = ST_MISS;
                  miss_d  = 1'b1;
               end
            end else if (tick) begin
               if (tick_q == period_q - CNT_W'(1)) begin
                  tick_d = '0;
                  pos_d  = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
               end else begin
                  tick_d = tick_q + CNT_W'(1);
               end
            end
         end
         ST_HIT: begin
            if (tick) begin
               if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                  state_d = ST_RUN;
                  pos_d   = '0;
                  tick_d  = '0;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         ST_MISS: begin
            if (tick) begin
               if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      led = '0;
      case (state_q)
         ST_RUN, ST_MISS: led[pos_q] = 1'b1;
         ST_HIT:          led = '1;
         default:         led = '0;
      endcase
   end

   assign state = state_q;
   assign score = score_q;
   assign hit   = hit_q;
   assign miss  = miss_q;

endmodule

// File: tb/tb_light_runner.sv
// Directed bench for light_runner: scripted game table plus multi-cycle corner sequences.
module tb_light_runner;

   logic       clk_in = 1'b0;
   logic       rst, slow_clk, btn;
   logic [7:0] led;
   logic [6:0] score;
   logic       hit, miss;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int hit_cnt = 0;
   int miss_cnt = 0;
   int viol = 0;
   logic prev_hit = 1'b0;
   logic prev_miss = 1'b0;

`ifdef LIGHT_RUNNER_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif
   localparam int P1 = SPEEDUP ? 18 : 20;

   typedef struct {
      int         ticks;
      bit         press;
      logic [1:0] st;
      logic [7:0] led;
      logic [6:0] score;
      int         hits;
      int         misses;
   } vec_t;

   vec_t tbl[13];

   light_runner dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .slow_clk (slow_clk),
      .btn      (btn),
      .led      (led),
      .score    (score),
      .hit      (hit),
      .miss     (miss),
      .state    (state)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      hit_cnt   <= hit_cnt + int'(hit);
      miss_cnt  <= miss_cnt + int'(miss);
      if ((hit && miss) || (hit && prev_hit) || (miss && prev_miss))
         viol <= viol + 1;
      prev_hit  <= hit;
      prev_miss <= miss;
   end

   initial begin
      #950000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in); #1 slow_clk = 1'b1;
         @(posedge clk_in); #1 slow_clk = 1'b0;
      end
      @(posedge clk_in);
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic press();
      @(posedge clk_in); #1 btn = 1'b1;
      repeat (3) @(posedge clk_in);
      #1 btn = 1'b0;
      repeat (4) @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic press_with_tick();
      @(posedge clk_in); #1 btn = 1'b1;
      @(posedge clk_in); #1 slow_clk = 1'b1;
      @(posedge clk_in); #1 slow_clk = 1'b0;
      @(posedge clk_in); #1 btn = 1'b0;
      repeat (4) @(posedge clk_in);
      @(negedge clk_in);
   endtask

   function automatic int next_p(input int p);
      if (!SPEEDUP) return p;
      return (p - 2 < 6) ? 6 : p - 2;
   endfunction

   initial begin
      int h0, m0, cnt, exp_p;
      rst = 1'b1; btn = 1'b0; slow_clk = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_state", int'(state), 0);
      check("rst_led",   int'(led),   0);
      check("rst_score", int'(score), 0);
      check("rst_hit",   int'(hit),   0);
      check("rst_miss",  int'(miss),  0);
      @(posedge clk_in); #1 rst = 1'b0;

      //          ticks   press  st     led     score  hits misses
      tbl[0]  = '{0,      1'b1, 2'd1, 8'h01, 7'd0, 0, 0};
      tbl[1]  = '{19,     1'b0, 2'd1, 8'h01, 7'd0, 0, 0};
      tbl[2]  = '{1,      1'b0, 2'd1, 8'h02, 7'd0, 0, 0};
      tbl[3]  = '{60,     1'b0, 2'd1, 8'h10, 7'd0, 0, 0};
      tbl[4]  = '{0,      1'b1, 2'd2, 8'hFF, 7'd1, 1, 0};
      tbl[5]  = '{0,      1'b1, 2'd2, 8'hFF, 7'd1, 0, 0};
      tbl[6]  = '{99,     1'b0, 2'd2, 8'hFF, 7'd1, 0, 0};
      tbl[7]  = '{1,      1'b0, 2'd1, 8'h01, 7'd1, 0, 0};
      tbl[8]  = '{2 * P1, 1'b0, 2'd1, 8'h04, 7'd1, 0, 0};
      tbl[9]  = '{0,      1'b1, 2'd3, 8'h04, 7'd1, 0, 1};
      tbl[10] = '{99,     1'b1, 2'd3, 8'h04, 7'd1, 0, 0};
      tbl[11] = '{1,      1'b0, 2'd0, 8'h00, 7'd1, 0, 0};
      tbl[12] = '{0,      1'b1, 2'd1, 8'h01, 7'd0, 0, 0};

      for (int v = 0; v < 13; v++) begin
         h0 = hit_cnt;
         m0 = miss_cnt;
         if (tbl[v].press) press();
         ticks(tbl[v].ticks);
         check($sformatf("vec%0d_state", v), int'(state), int'(tbl[v].st));
         check($sformatf("vec%0d_led", v),   int'(led),   int'(tbl[v].led));
         check($sformatf("vec%0d_score", v), int'(score), int'(tbl[v].score));
         check($sformatf("vec%0d_hits", v),   hit_cnt - h0,  tbl[v].hits);
         check($sformatf("vec%0d_misses", v), miss_cnt - m0, tbl[v].misses);
      end

      // press lands on the same cycle as the step from pos 4 to pos 5
      ticks(99);
      check("coinc_pre_led", int'(led), 8'h10);
      h0 = hit_cnt;
      m0 = miss_cnt;
      press_with_tick();
      check("coinc_state", int'(state), 2);
      check("coinc_led",   int'(led),   8'hFF);
      check("coinc_score", int'(score), 1);
      check("coinc_hits",  hit_cnt - h0,  1);
      check("coinc_miss",  miss_cnt - m0, 0);

      // reset in the middle of a HIT hold
      ticks(5);
      h0 = hit_cnt;
      m0 = miss_cnt;
      @(posedge clk_in); #1 rst = 1'b1;
      @(posedge clk_in); #1 rst = 1'b0;
      @(negedge clk_in);
      check("midrst_state", int'(state), 0);
      check("midrst_led",   int'(led),   0);
      check("midrst_score", int'(score), 0);
      check("midrst_hit",   int'(hit),   0);
      check("midrst_miss",  int'(miss),  0);
      repeat (4) @(negedge clk_in);
      check("midrst_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);

      // step period across consecutive hits
      press();
      check("spd_start_state", int'(state), 1);
      exp_p = 20;
      for (int k = 0; k < 9; k++) begin
         cnt = 0;
         while (led == 8'h01 && cnt < 40) begin
            ticks(1);
            cnt++;
         end
         check($sformatf("period%0d", k), cnt, exp_p);
         ticks(3 * exp_p);
         check($sformatf("spd%0d_led", k), int'(led), 8'h10);
         h0 = hit_cnt;
         press();
         check($sformatf("spd%0d_state", k), int'(state), 2);
         check($sformatf("spd%0d_score", k), int'(score), k + 1);
         check($sformatf("spd%0d_hits", k), hit_cnt - h0, 1);
         exp_p = next_p(exp_p);
         cnt = 0;
         while (state == 2'd2 && cnt < 150) begin
            ticks(1);
            cnt++;
         end
         check($sformatf("hold%0d", k), cnt, 100);
         check($sformatf("spd%0d_rerun_led", k), int'(led), 8'h01);
      end

      // score saturates at 99
      for (int i = 0; i < 91; i++) begin
         ticks(4 * exp_p);
         press();
         check($sformatf("sat%0d_state", i), int'(state), 2);
         check($sformatf("sat%0d_score", i), int'(score), (10 + i > 99) ? 99 : 10 + i);
         exp_p = next_p(exp_p);
         ticks(100);
      end
      check("sat_final_state", int'(state), 1);
      check("sat_final_led",   int'(led),   8'h01);

      check("pulse_width_overlap", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
